uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

UART transmitter with a write-side FIFO, forming the transmit half of the host serial link alongside the existing receive path in `top`. Bytes written by the command/readout logic are queued and then serialised onto `uartTx_pin` as 8N1 frames, LSB first, at a baud rate derived from the 100 MHz system clock. The block drives `uartTx_pin` directly and is clocked by `CLK`.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ / BAUD`, truncated; 10416 at the defaults, giving a bit time of 104.16 µs.
- `FIFO_DEPTH`, 16: number of queued bytes. Must be a power of two, ≥ 2.
- `CLK`  in  1: system clock, rising edge.
- `Reset`  in  1: asynchronous reset, active-low.
- `tx_data`  in  8: byte to enqueue.
- `tx_wr`  in  1: one-cycle write strobe. Sampled on the rising edge of `CLK`.
- `tx_full`  out  1: FIFO holds `FIFO_DEPTH` entries.
- `tx_empty`  out  1: FIFO holds 0 entries.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1): number of bytes queued, excluding the byte in flight.
- `tx_busy`  out  1: high while a frame is on the line (FSM not in IDLE).
- `tx_overflow`  out  1: sticky; set when a write is dropped.
- `uartTx_pin`  out  1: serial output, idle high.

## Operation
- **FIFO:** circular buffer with read and write pointers of width $clog2(FIFO_DEPTH). Pointers wrap modulo `FIFO_DEPTH`.
- **Write acceptance:** `tx_wr` while `tx_full` is low stores `tx_data` and increments the count.
- **Write while full:** `tx_wr` while `tx_full` is high is dropped and sets `tx_overflow`. Fullness is evaluated before any pop in the same cycle, so the write is dropped even if a pop occurs on that edge.
- **Simultaneous write and pop (not full):** `fifo_count` is unchanged and both pointers advance.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `uartTx_pin`=1. If the FIFO is non-empty, pop into the shift register, clear the bit counter, go to START.
  - START: `uartTx_pin`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `uartTx_pin` = shift[0], LSB first. Shift right every `CLKS_PER_BIT` cycles. After bit index 7, go to STOP.
  - STOP: `uartTx_pin`=1 for `CLKS_PER_BIT` cycles. Then:
    - if the FIFO is non-empty, pop and go directly to START, with no idle gap;
    - otherwise go to IDLE.
- **Baud counter:** counts from 0 to `CLKS_PER_BIT`−1 and is reloaded to 0 on every state entry.
- **Registered output:** `uartTx_pin` is a register output, so it has no combinational path from inputs.
- **Reset values:** `uartTx_pin`=1, `tx_busy`=0, `tx_full`=0, `tx_empty`=1, `fifo_count`=0, `tx_overflow`=0, pointers=0, state=IDLE.
- **Reset mid-frame:** the line returns high immediately (asynchronously), the frame is abandoned, and all queued bytes are discarded.

## Timing
- **Write latency:** a write sampled at edge k with the FSM in IDLE and the FIFO empty:
  - `fifo_count`=1 after edge k;
  - at edge k+1 the pop occurs, `uartTx_pin` falls, `tx_busy` rises, and `fifo_count` returns to 0.
- **Frame length:** exactly 10·`CLKS_PER_BIT` cycles (104 160 at the defaults). Every bit is exactly `CLKS_PER_BIT` cycles.
- **Back-to-back bytes:** the next start bit begins on the cycle after the last stop-bit cycle.
- **`tx_busy`:** falls on the edge the FSM enters IDLE.
- **Status outputs:** `tx_full`, `tx_empty` and `fifo_count` are registered and reflect the state after the current edge.
- **Throughput:** sustained 1 byte per 10 bit times. Writers must respect `tx_full`.

## Test plan
- **Reset:** hold `Reset`=0 for 100 ns, then release. Outputs must hold their reset values, with `uartTx_pin`=1 and no transition for 1 ms.
- **Single byte 0x55:** write 0x55. The line must show start 0, then 1,0,1,0,1,0,1,0, then stop 1, each bit 10416 cycles ±0. `tx_busy` is high for 104 160 cycles.
- **Back-to-back and loopback:** write 0xFF, 0x55, 0x01, 0xB1 on consecutive cycles.
  - `fifo_count` peaks at 3.
  - The four frames are contiguous with no idle gap, decoded LSB first as 0xFF, 0x55, 0x01, 0xB1.
  - Looped into `top`'s `uartRx_pin`, the receiver reproduces the same bytes.
- **Fill and overflow:** write 17 bytes 0x00–0x10 in consecutive cycles while the FIFO starts empty.
  - The first byte is popped immediately, so 0x00–0x10 all fit.
  - An 18th write of 0x11 at full must be dropped: `tx_overflow`=1 and 0x11 never appears on the line.
  - Separately, write while full on the same edge as a STOP→START pop: the write must be dropped.
- **Reset mid-frame:** assert `Reset` during DATA bit 3 of 0xA5 with 2 bytes queued.
  - `uartTx_pin` goes high within the same cycle, with no clock edge needed.
  - After release, `fifo_count`=0 and no further frames are sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 LSB-first UART transmitter
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                               CLK,
    input  logic                               Reset,
    input  logic [7:0]                         tx_data,
    input  logic                               tx_wr,
    output logic                               tx_full,
    output logic                               tx_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               tx_busy,
    output logic                               tx_overflow,
    output logic                               uartTx_pin
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int NW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_nx;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift, shift_nx;
    logic            bit_done, push, pop, pin_nx;

    assign bit_done = baud_cnt == CW'(CPB - 1);
    assign tx_full  = fifo_count == NW'(FIFO_DEPTH);
    assign tx_empty = fifo_count == '0;
    assign tx_busy  = state != IDLE;
    assign push     = tx_wr && !tx_full;
    assign pop      = !tx_empty && (state == IDLE || (state == STOP && bit_done));

    // state register
    always_ff @(posedge CLK or negedge Reset)
        if (!Reset) state <= IDLE;
        else        state <= state_nx;

    // next state: STOP chains straight into START when another byte is waiting
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pop) state_nx = START;
            START:   if (bit_done) state_nx = DATA;
            DATA:    if (bit_done && bit_idx == 3'd7) state_nx = STOP;
            STOP:    if (bit_done) state_nx = pop ? START : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // next shift contents and the line level to register for the coming state
    always_comb begin
        shift_nx = pop ? mem[rd_ptr] : (state == DATA && bit_done) ? shift >> 1 : shift;
        pin_nx   = state_nx == START ? 1'b0 : state_nx == DATA ? shift_nx[0] : 1'b1;
    end

    // pointers, occupancy, baud/bit counters and the registered serial output
    always_ff @(posedge CLK or negedge Reset)
        if (!Reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            tx_overflow <= 1'b0;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            uartTx_pin  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + NW'(push) - NW'(pop);
            if (tx_wr && tx_full) tx_overflow <= 1'b1;
            baud_cnt   <= (state_nx != state || bit_done || state == IDLE) ? '0 : baud_cnt + 1'b1;
            bit_idx    <= pop ? 3'd0 : (state == DATA && bit_done) ? bit_idx + 1'b1 : bit_idx;
            shift      <= shift_nx;
            uartTx_pin <= pin_nx;
        end

    // byte storage, no reset needed since occupancy gates every read
    always_ff @(posedge CLK)
        if (push) mem[wr_ptr] <= tx_data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scoreboard bench for uart_tx_fifo
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int CPB   = 11;
    localparam int DEPTH = 16;

    logic       CLK = 0, Reset = 0, tx_wr = 0;
    logic [7:0] tx_data = '0;
    logic       tx_full, tx_empty, tx_busy, tx_overflow, uartTx_pin;
    logic [4:0] fifo_count;

    int         checks = 0, errors = 0, cyc = 0, toggles = 0, mcnt = 0;
    logic       pin_q = 1'b1, mbusy = 1'b0;
    logic [9:0] msh = '0;
    logic [7:0] exp_q[$];
    int         start_cyc[$];

    uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD(9_000_000), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_full(tx_full), .tx_empty(tx_empty), .fifo_count(fifo_count),
        .tx_busy(tx_busy), .tx_overflow(tx_overflow), .uartTx_pin(uartTx_pin)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // line receiver: samples mid-bit and compares each decoded byte against the scoreboard
    always @(negedge CLK) begin
        if (!Reset) mbusy = 1'b0;
        else begin
            if (uartTx_pin !== pin_q) toggles++;
            if (!mbusy && uartTx_pin === 1'b0) begin
                mbusy = 1'b1;
                mcnt  = 0;
                start_cyc.push_back(cyc);
            end else if (mbusy) mcnt++;
            if (mbusy && mcnt % CPB == CPB / 2) msh[mcnt / CPB] = uartTx_pin;
            if (mbusy && mcnt == 9 * CPB + CPB / 2) begin
                mbusy = 1'b0;
                check("start_bit", 32'(msh[0]), 0);
                check("stop_bit", 32'(msh[9]), 1);
                check("frame_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("frame_data", 32'(msh[8:1]), 32'(exp_q.pop_front()));
            end
        end
        pin_q = uartTx_pin;
    end

    initial begin
        int t0, e0, n, run, nruns, bad, peak;
        logic prev;
        logic [7:0] b2b [4] = '{8'hFF, 8'h55, 8'h01, 8'hB1};

        #50;
        check("rst_pin", 32'(uartTx_pin), 1);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_full", 32'(tx_full), 0);
        check("rst_empty", 32'(tx_empty), 1);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_overflow", 32'(tx_overflow), 0);
        #50 Reset = 1;
        @(negedge CLK);
        t0 = toggles;
        repeat (200) @(negedge CLK);
        check("idle_toggles", 32'(toggles - t0), 0);
        check("idle_pin", 32'(uartTx_pin), 1);

        exp_q.push_back(8'h55);
        tx_data = 8'h55; tx_wr = 1;
        @(negedge CLK);
        tx_wr = 0;
        check("wr_count", 32'(fifo_count), 1);
        check("wr_pin", 32'(uartTx_pin), 1);
        check("wr_busy", 32'(tx_busy), 0);
        @(negedge CLK);
        check("pop_pin", 32'(uartTx_pin), 0);
        check("pop_busy", 32'(tx_busy), 1);
        check("pop_count", 32'(fifo_count), 0);
        n = 0; run = 0; nruns = 0; bad = 0; prev = uartTx_pin;
        while (tx_busy === 1'b1 && n < 20 * CPB) begin
            n++;
            if (uartTx_pin !== prev) begin
                if (run != CPB) bad++;
                nruns++;
                run = 0;
                prev = uartTx_pin;
            end
            run++;
            @(negedge CLK);
        end
        if (run != CPB) bad++;
        nruns++;
        check("busy_len", 32'(n), 32'(10 * CPB));
        check("bit_runs", 32'(nruns), 10);
        check("bit_widths", 32'(bad), 0);
        check("single_drained", 32'(exp_q.size()), 0);

        start_cyc.delete();
        peak = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(b2b[i]);
            tx_data = b2b[i]; tx_wr = 1;
            @(negedge CLK);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        tx_wr = 0;
        repeat (5) begin
            @(negedge CLK);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        check("b2b_peak", 32'(peak), 3);
        n = 0;
        while ((tx_busy === 1'b1 || exp_q.size() > 0) && n < 80 * CPB) begin n++; @(negedge CLK); end
        check("b2b_drained", 32'(exp_q.size()), 0);
        check("b2b_idle", 32'(tx_busy), 0);
        check("b2b_frames", 32'(start_cyc.size()), 4);
        if (start_cyc.size() == 4)
            for (int i = 1; i < 4; i++) check("b2b_gap", 32'(start_cyc[i] - start_cyc[i-1]), 32'(10 * CPB));

        e0 = 0;
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back(8'(i));
            tx_data = 8'(i); tx_wr = 1;
            @(negedge CLK);
            if (i == 0) e0 = cyc;
        end
        check("fill_count", 32'(fifo_count), 16);
        check("fill_full", 32'(tx_full), 1);
        check("fill_no_ovf", 32'(tx_overflow), 0);
        tx_data = 8'h11;
        @(negedge CLK);
        tx_wr = 0;
        check("ovf_set", 32'(tx_overflow), 1);
        check("ovf_count", 32'(fifo_count), 16);
        while (cyc < e0 + 10 * CPB) @(negedge CLK);
        check("prepop_count", 32'(fifo_count), 16);
        check("prepop_busy", 32'(tx_busy), 1);
        tx_data = 8'h22; tx_wr = 1;
        @(negedge CLK);
        tx_wr = 0;
        check("pop_edge_count", 32'(fifo_count), 15);
        check("pop_edge_full", 32'(tx_full), 0);
        check("pop_edge_start", 32'(uartTx_pin), 0);
        n = 0;
        while ((tx_busy === 1'b1 || exp_q.size() > 0) && n < 200 * CPB) begin n++; @(negedge CLK); end
        check("fill_drained", 32'(exp_q.size()), 0);
        check("fill_idle", 32'(tx_busy), 0);

        tx_data = 8'hA5; tx_wr = 1;
        @(negedge CLK);
        e0 = cyc;
        tx_data = 8'h3C;
        @(negedge CLK);
        tx_data = 8'h0F;
        @(negedge CLK);
        tx_wr = 0;
        while (cyc < e0 + 1 + 4 * CPB + CPB / 2) @(negedge CLK);
        check("mid_count", 32'(fifo_count), 2);
        check("mid_bit3", 32'(uartTx_pin), 0);
        #2 Reset = 0;
        #1;
        check("async_pin", 32'(uartTx_pin), 1);
        check("async_count", 32'(fifo_count), 0);
        check("async_busy", 32'(tx_busy), 0);
        repeat (3) @(negedge CLK);
        Reset = 1;
        t0 = toggles;
        repeat (300) @(negedge CLK);
        check("post_rst_toggles", 32'(toggles - t0), 0);
        check("post_rst_count", 32'(fifo_count), 0);
        check("post_rst_empty", 32'(tx_empty), 1);
        check("post_rst_busy", 32'(tx_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
